// File: rtl/pll_cen_gen_if.sv
// Control/strobe bundle of the PLL clock-enable generator.
// The controller side drives rates and enables; the generator returns strobes and ready.
interface pll_cen_gen_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ACC_W    = 32
);
   logic [CHANNELS-1:0]       ch_en;
   logic                      sync;
   logic [CHANNELS-1:0]       inc_we;
   logic [CHANNELS*ACC_W-1:0] inc_data;
   logic [CHANNELS-1:0]       cen;
   logic                      ready;

   modport master (
      output ch_en, sync, inc_we, inc_data,
      input  cen, ready
   );

   modport slave (
      input  ch_en, sync, inc_we, inc_data,
      output cen, ready
   );
endinterface

// File: rtl/pll_cen_gen.sv
// Multi-channel phase-accumulator clock-enable generator behind the system PLL.
// Outputs run only after the synchronised lock has been stable for SETTLE_CYCLES.
module pll_cen_gen #(
   parameter int unsigned     CHANNELS      = 2,
   parameter int unsigned     ACC_W         = 32,
   parameter int unsigned     SETTLE_CYCLES = 1024,
   parameter logic [ACC_W-1:0] DEFAULT_INC  = '0
) (
   input  logic           refclk,
   input  logic           rst_n,
   input  logic           locked,
   pll_cen_gen_if.slave   bus
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_next_s;
   logic                lock_meta_r;
   logic                lock_s_r;
   logic                ready_r;
   logic                acc_run_s;
   logic [CHANNELS-1:0] cen_r;
   logic [ACC_W-1:0]    acc_r [CHANNELS];
   logic [ACC_W-1:0]    inc_r [CHANNELS];
   logic [ACC_W:0]      sum_s [CHANNELS];

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_r <= 1'b0;
         lock_s_r    <= 1'b0;
      end else begin
         lock_meta_r <= locked;
         lock_s_r    <= lock_meta_r;
      end
   end

   // FSM state, settle counter and ready register.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_WAIT;
         cnt_r   <= '0;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         ready_r <= (state_next_s == ST_RUN);
      end
   end

   // Next-state and settle counter logic.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_WAIT: begin
            cnt_next_s = '0;
            if (lock_s_r) begin
               state_next_s = ST_SETTLE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_SETTLE: begin
            if (!lock_s_r) begin
               state_next_s = ST_WAIT;
               cnt_next_s   = '0;
            end else if (cnt_r == SETTLE_LAST) begin
               state_next_s = ST_RUN;
               cnt_next_s   = '0;
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!lock_s_r) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         default: begin
            state_next_s = ST_WAIT;
            cnt_next_s   = '0;
         end
      endcase
   end

   // Accumulate only while staying in RUN; a lock loss or sync clears instead.
   always_comb begin
      acc_run_s = (state_r == ST_RUN) && lock_s_r && !bus.sync;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         sum_s[i] = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
      end
   end

   // Per-channel phase accumulators and registered strobes.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cen_r <= '0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            acc_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (acc_run_s && bus.ch_en[i]) begin
               acc_r[i] <= sum_s[i][ACC_W-1:0];
               cen_r[i] <= sum_s[i][ACC_W];
            end else begin
               acc_r[i] <= '0;
               cen_r[i] <= 1'b0;
            end
         end
      end
   end

   // Increment registers; writable in any state, restored only by rst_n.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            inc_r[i] <= DEFAULT_INC;
         end
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.inc_we[i]) begin
               inc_r[i] <= bus.inc_data[i*ACC_W +: ACC_W];
            end else begin
               inc_r[i] <= inc_r[i];
            end
         end
      end
   end

   assign bus.cen   = cen_r;
   assign bus.ready = ready_r;

endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed self-checking bench for pll_cen_gen (ACC_W=8, SETTLE_CYCLES=4, DEFAULT_INC=32).
module tb_pll_cen_gen;

   logic refclk;
   logic rst_n;
   logic locked;
   int   n_checks;
   int   n_fail;

   pll_cen_gen_if #(.CHANNELS(2), .ACC_W(8)) bus ();

   pll_cen_gen #(
      .CHANNELS      (2),
      .ACC_W         (8),
      .SETTLE_CYCLES (4),
      .DEFAULT_INC   (8'd32)
   ) dut (
      .refclk (refclk),
      .rst_n  (rst_n),
      .locked (locked),
      .bus    (bus.slave)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic apply(input logic [1:0] we, input logic [7:0] d1, input logic [7:0] d0,
                        input logic s);
      bus.inc_we   = we;
      bus.inc_data = {d1, d0};
      bus.sync     = s;
      step();
      bus.inc_we   = 2'b00;
      bus.sync     = 1'b0;
   endtask

   // Counts 7 edges from a lock rise; ready must appear only on the 7th.
   task automatic lock_up(input string tag);
      logic early;
      logic [1:0] seen;
      early = 1'b0;
      seen  = 2'b00;
      for (int k = 1; k <= 7; k++) begin
         step();
         seen = seen | bus.cen;
         if (k < 7) early = early | bus.ready;
      end
      check({tag, "_ready"}, bus.ready, 1);
      check({tag, "_early"}, early, 0);
      check({tag, "_cen"}, seen, 0);
   endtask

   initial begin
      logic [15:0] e0;
      logic [15:0] e1;
      logic        seen0;
      logic [1:0]  seen;
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      locked       = 1'b0;
      bus.ch_en    = 2'b11;
      bus.sync     = 1'b0;
      bus.inc_we   = 2'b00;
      bus.inc_data = 16'h0000;

      repeat (3) step();
      check("rst_cen", bus.cen, 0);
      check("rst_ready", bus.ready, 0);
      rst_n = 1'b1;
      repeat (3) step();
      check("wait_ready", bus.ready, 0);

      locked = 1'b1;
      lock_up("lock");

      // ch0 inc=64 -> every 4th, ch1 inc=96 -> spacing 3,3,2
      apply(2'b11, 8'd96, 8'd64, 1'b1);
      check("sync_cen", bus.cen, 0);
      e0 = 16'h8888;
      e1 = 16'hA4A4;
      for (int k = 0; k < 16; k++) begin
         step();
         check("rate", bus.cen, {30'd0, e1[k], e0[k]});
      end

      // sync lands on the edge where ch1 would carry
      apply(2'b11, 8'd128, 8'd64, 1'b1);
      step();
      check("ph1", bus.cen, 0);
      bus.sync = 1'b1;
      step();
      bus.sync = 1'b0;
      check("sync_win", bus.cen, 0);
      e0 = 16'h0088;
      e1 = 16'h00AA;
      for (int k = 0; k < 8; k++) begin
         step();
         check("align", bus.cen, {30'd0, e1[k], e0[k]});
      end

      apply(2'b01, 8'd0, 8'd0, 1'b0);
      seen0 = 1'b0;
      repeat (1000) begin
         step();
         seen0 = seen0 | bus.cen[0];
      end
      check("inc_zero", seen0, 0);

      apply(2'b01, 8'd0, 8'd255, 1'b1);
      step();
      check("ff_first", bus.cen[0], 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("ff_run", bus.cen[0], 1);
      end

      // lock loss reaches the outputs after 3 edges
      locked = 1'b0;
      step();
      check("drop1_ready", bus.ready, 1);
      step();
      check("drop2_ready", bus.ready, 1);
      check("drop2_cen0", bus.cen[0], 1);
      step();
      check("drop3_ready", bus.ready, 0);
      check("drop3_cen", bus.cen, 0);

      // one-cycle lock glitch during SETTLE restarts the full settle
      locked = 1'b1;
      repeat (3) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      lock_up("glitch");

      step();
      step();
      check("pre_rst_cen0", bus.cen[0], 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_cen", bus.cen, 0);
      check("rst_async_ready", bus.ready, 0);
      bus.ch_en = 2'b01;
      step();
      rst_n = 1'b1;
      lock_up("relock");
      e0 = 16'h0080;
      for (int k = 0; k < 8; k++) begin
         step();
         check("dflt_inc", bus.cen, {31'd0, e0[k]});
      end

      bus.ch_en = 2'b00;
      apply(2'b01, 8'd0, 8'd255, 1'b0);
      seen = 2'b00;
      repeat (10) begin
         step();
         seen = seen | bus.cen;
      end
      check("chen_off", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
